alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Multi-cycle, parametrised successor to the single-cycle MIPS ALU.
- Keeps the existing 4-bit ALU control encoding for logic, add/sub and slt.
- Adds signed overflow detection, unsigned slt, iterative multiply and iterative divide with HI/LO results.
- Sits in the EX stage of the multi-cycle MIPS core behind a valid/ready handshake, so the control FSM stalls while mult/div run.

Parameters:
- WIDTH, 32, operand and result width; any even value ≥ 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- alu_ctr  in  4  operation code.
- di1  in  WIDTH  operand A.
- di2  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result; LO for mult, quotient for div.
- out_hi  out  WIDTH  HI for mult, remainder for div; 0 otherwise.
- zero  out  1  out == 0.
- ovf  out  1  signed overflow on add/sub.
- div_by_zero  out  1  div issued with di2 == 0.

Behaviour:
- Reset (sync, active-high, highest priority; aborts any operation in progress):
  - state = IDLE, in_ready = 1.
  - out_valid = 0; out, out_hi, ovf, div_by_zero = 0; zero = 1.
- Operation codes, unchanged from the existing ALU:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
  - New: 0011 SLTU, 1000 MULTU (unsigned, 2·WIDTH product), 1001 DIVU (unsigned).
  - Any other code: out = 0, out_hi = 0, latency 1.
- Handshake:
  - Request accepted when in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - Operands and alu_ctr are captured at acceptance; later input changes are ignored.
- FSM:
  - IDLE → DONE on accept of a 1-cycle op (logic, add, sub, slt, sltu, unknown, DIVU with di2 = 0).
  - IDLE → BUSY on accept of MULTU, or DIVU with di2 ≠ 0; counter loaded with WIDTH.
  - BUSY: one shift-add (mult) or one restoring-subtract (div) step per cycle; counter decrements; BUSY → DONE when counter reaches 1 and its step completes.
  - DONE: out_valid = 1, all outputs held stable. DONE → IDLE on out_ready.
- Latency:
  - 1-cycle ops: out_valid in the cycle after acceptance.
  - MULTU/DIVU: out_valid WIDTH+1 cycles after acceptance.
  - A new request can be accepted the cycle after the DONE→IDLE transition; no back-to-back overlap.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf = signed overflow: add → operands same sign, result sign differs; sub → operands differ in sign, result sign ≠ di1 sign. ovf = 0 for all other ops.
  - SLT/SLTU: out = {WIDTH-1 zeros, lt}.
  - zero evaluates out only; out_hi is ignored.
  - DIVU with di2 = 0: out = all ones, out_hi = di1, div_by_zero = 1.
- Outputs are registered and change only on the transition into DONE or on reset.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR, ALU_MULTU, ALU_DIVU localparams.
  - State encoding IDLE / BUSY / DONE.
- The core MIPS control unit imports the same opcode constants.
- One natural sub-module, alu_muldiv_iter: iterative engine with start, op_is_div, a, b → busy, done, hi, lo.
- Parent alu_mc keeps the FSM, handshake, the 1-cycle datapath and the flags.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → one cycle later out = 0x80000000, ovf = 1, zero = 0; in_ready back to 1 the following cycle.
- SUB 5 − 5, then SLT 0xFFFFFFFF < 0x00000001, then SLTU with the same operands → out = 0 / zero = 1; out = 1; out = 0 / zero = 1.
- MULTU 0xFFFFFFFF × 0x00000002 → out_valid exactly 33 cycles after accept; out_hi = 0x00000001, out = 0xFFFFFFFE; in_ready = 0 throughout.
- DIVU 100 / 7 → out = 14, out_hi = 2 after 33 cycles. DIVU 9 / 0 → 1 cycle later: out = 0xFFFFFFFF, out_hi = 9, div_by_zero = 1.
- Backpressure: complete an AND 0xF0F0 & 0x0FF0, hold out_ready = 0 for 5 cycles while toggling di1/di2/in_valid → out = 0x00F0 stable, in_ready = 0, no new accept; accept resumes after out_ready.
- Reset mid-MULTU (cycle 10 of BUSY), then MULTU 3 × 4 → out_valid stays 0, in_ready = 1 the cycle after rst; fresh MULTU returns out = 12, out_hi = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode constants and FSM state encoding shared by the ALU and the MIPS
// control unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// done accompanies the final step, with hi/lo already showing the finished result.
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] hi_r, lo_r, b_r;
    logic             div_r, busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   add_s, shifted_s, trial_s;
    logic [WIDTH-1:0] hi_nx_s, lo_nx_s;

    // One multiply or divide step computed from the current partial state.
    always_comb begin
        add_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        shifted_s = {hi_r, lo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, b_r};
        if (div_r) begin
            // A clear top bit means the shifted remainder was >= divisor.
            if (!trial_s[WIDTH]) begin
                hi_nx_s = trial_s[WIDTH-1:0];
                lo_nx_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx_s = shifted_s[WIDTH-1:0];
                lo_nx_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx_s = add_s[WIDTH:1];
            lo_nx_s = {add_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Operand load on start, then one step per cycle while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            div_r  <= 1'b0;
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (start) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= a;
            b_r    <= b;
            div_r  <= op_is_div;
            busy_r <= 1'b1;
            cnt_r  <= CNT_W'(WIDTH);
        end else if (busy_r) begin
            hi_r   <= hi_nx_s;
            lo_r   <= lo_nx_s;
            cnt_r  <= cnt_r - CNT_ONE;
            busy_r <= (cnt_r != CNT_ONE);
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (cnt_r == CNT_ONE);
    assign hi   = hi_nx_s;
    assign lo   = lo_nx_s;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith/compare ops plus iterative
// MULTU/DIVU, all behind a valid/ready handshake with registered results.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctr,
    input  logic [WIDTH-1:0] di1,
    input  logic [WIDTH-1:0] di2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             ovf,
    output logic             div_by_zero
);

    state_e           state_r, state_nx_s;
    logic             accept_s, is_long_s, eng_start_s;
    logic             eng_busy_s, eng_done_s;
    logic [WIDTH-1:0] eng_hi_s, eng_lo_s;
    logic [WIDTH-1:0] sum_s, diff_s, res_s, res_hi_s;
    logic             res_ovf_s, res_dbz_s;
    logic [WIDTH-1:0] out_r, out_hi_r;
    logic             zero_r, ovf_r, dbz_r;

    assign accept_s    = in_valid && in_ready;
    assign is_long_s   = (alu_ctr == ALU_MULTU) ||
                         ((alu_ctr == ALU_DIVU) && (di2 != {WIDTH{1'b0}}));
    assign eng_start_s = accept_s && is_long_s;
    assign sum_s       = di1 + di2;
    assign diff_s      = di1 - di2;

    alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (eng_start_s),
        .op_is_div (alu_ctr == ALU_DIVU),
        .a         (di1),
        .b         (di2),
        .busy      (eng_busy_s),
        .done      (eng_done_s),
        .hi        (eng_hi_s),
        .lo        (eng_lo_s)
    );

    // Single-cycle datapath; long ops and unknown codes fall through to zeros.
    always_comb begin
        res_s     = {WIDTH{1'b0}};
        res_hi_s  = {WIDTH{1'b0}};
        res_ovf_s = 1'b0;
        res_dbz_s = 1'b0;
        case (alu_ctr)
            ALU_AND:  res_s = di1 & di2;
            ALU_OR:   res_s = di1 | di2;
            ALU_NOR:  res_s = ~(di1 | di2);
            ALU_ADD: begin
                res_s     = sum_s;
                res_ovf_s = (di1[WIDTH-1] == di2[WIDTH-1]) && (sum_s[WIDTH-1] != di1[WIDTH-1]);
            end
            ALU_SUB: begin
                res_s     = diff_s;
                res_ovf_s = (di1[WIDTH-1] != di2[WIDTH-1]) && (diff_s[WIDTH-1] != di1[WIDTH-1]);
            end
            ALU_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(di1) < $signed(di2))};
            ALU_SLTU: res_s = {{(WIDTH-1){1'b0}}, (di1 < di2)};
            ALU_DIVU: begin
                if (di2 == {WIDTH{1'b0}}) begin
                    res_s     = {WIDTH{1'b1}};
                    res_hi_s  = di1;
                    res_dbz_s = 1'b1;
                end else begin
                    res_dbz_s = 1'b0;
                end
            end
            default:  res_s = {WIDTH{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nx_s;
    end

    // Next-state logic; a BUSY engine that went idle without done recovers to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = is_long_s ? BUSY : DONE;
                else          state_nx_s = IDLE;
            end
            BUSY: begin
                if (eng_done_s)       state_nx_s = DONE;
                else if (!eng_busy_s) state_nx_s = IDLE;
                else                  state_nx_s = BUSY;
            end
            DONE: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Result registers load only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r    <= {WIDTH{1'b0}};
            out_hi_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            ovf_r    <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (accept_s && !is_long_s) begin
            out_r    <= res_s;
            out_hi_r <= res_hi_s;
            zero_r   <= (res_s == {WIDTH{1'b0}});
            ovf_r    <= res_ovf_s;
            dbz_r    <= res_dbz_s;
        end else if ((state_r == BUSY) && eng_done_s) begin
            out_r    <= eng_lo_s;
            out_hi_r <= eng_hi_s;
            zero_r   <= (eng_lo_s == {WIDTH{1'b0}});
            ovf_r    <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            out_r    <= out_r;
        end
    end

    assign out         = out_r;
    assign out_hi      = out_hi_r;
    assign zero        = zero_r;
    assign ovf         = ovf_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc plus hand-written sequences for
// backpressure and reset during an iterative multiply.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic         zero, ovf, div_by_zero;
    logic [3:0]   alu_ctr;
    logic [W-1:0] di1, di2, out, out_hi;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, eo, eh;
        logic         eovf, ez, edbz;
        int           lat;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctr(alu_ctr), .di1(di1), .di2(di2), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_hi(out_hi), .zero(zero),
        .ovf(ovf), .div_by_zero(div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int  lat, guard;
        bit  ready_seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        alu_ctr  = v.op;
        di1      = v.a;
        di2      = v.b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_ctr  = ALU_AND;
        di1      = $urandom;
        di2      = $urandom;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_out"}, out, v.eo);
        chk({tag, "_out_hi"}, out_hi, v.eh);
        chk({tag, "_ovf"}, ovf, v.eovf);
        chk({tag, "_zero"}, zero, v.ez);
        chk({tag, "_dbz"}, div_by_zero, v.edbz);
        chk({tag, "_ready_while_busy"}, ready_seen | in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{ALU_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{ALU_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[4]  = '{ALU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0, 33};
        vecs[5]  = '{ALU_DIVU,  32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 1'b0, 1'b0, 33};
        vecs[6]  = '{ALU_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{ALU_OR,    32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{ALU_NOR,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{ALU_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[10] = '{ALU_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{4'b0101,   32'h00000005, 32'h00000003, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[12] = '{ALU_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[13] = '{ALU_DIVU,  32'd7,        32'd100,      32'd0,        32'd7, 1'b0, 1'b1, 1'b0, 33};
        vecs[14] = '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33};
        vecs[15] = '{ALU_SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctr = 4'b0000; di1 = 32'h0; di2 = 32'h0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_out_hi", out_hi, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_dbz", div_by_zero, 0);

        for (int i = 0; i < 16; i++) run_op(i, vecs[i]);

        // Backpressure: result held, no accept while out_ready is low.
        alu_ctr = ALU_AND; di1 = 32'h0000F0F0; di2 = 32'h00000FF0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            di1 = $urandom; di2 = $urandom; alu_ctr = ALU_OR;
            in_valid = k[0];
            tick();
            chk("bp_out_hold", out, 32'h000000F0);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_no_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ready_resume", in_ready, 1);
        chk("bp_out_after", out, 32'h000000F0);
        run_op(20, vecs[7]);

        // Reset during BUSY cycle 10 of a multiply.
        alu_ctr = ALU_MULTU; di1 = 32'hFFFFFFFF; di2 = 32'h00000002; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk("mid_busy_no_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_zero", zero, 1);
        repeat (30) tick();
        chk("mid_rst_still_idle", out_valid, 0);
        run_op(21, '{ALU_MULTU, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 33});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
